// File: rtl/snake_body_reader.sv
// Snapshots a packed snake body and streams its segments head-first over a valid/ready port.
// Optional self-collision detection is enabled by defining SNAKE_SELF_COLLIDE_EN.
`timescale 1ns/1ps
module snake_body_reader #(
  parameter int N       = 8,
  parameter int MAX_LEN = 16,
  localparam int LW     = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [LW-1:0]        length,
  input  logic [N*MAX_LEN-1:0] body_in,
  output logic [N-1:0]         seg_out,
  output logic [LW-1:0]        seg_index,
  output logic                 seg_valid,
  input  logic                 seg_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 collide,
  output logic [1:0]           dbg_state
);

  // Handshake: a segment transfers on every rising edge where seg_valid & seg_ready;
  // seg_out/seg_index stay stable while seg_valid is high and seg_ready is low.
  typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd1, FINISH = 2'd2} state_t;

  localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);
  localparam logic [LW-1:0] ONE       = LW'(1);

  state_t               state;
  logic [N*MAX_LEN-1:0] snap_q;
  logic [LW-1:0]        len_q;
  logic [LW-1:0]        len_c;
  logic [LW-1:0]        next_idx;
  logic                 start_acc;
  logic                 hs;
  logic                 last_seg;

  function automatic logic [N-1:0] seg_at(input logic [N*MAX_LEN-1:0] vec,
                                          input logic [LW-1:0] k);
    seg_at = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (k == LW'(i)) seg_at = vec[N*(MAX_LEN-1-i) +: N];
    end
  endfunction

  assign len_c     = (length > MAX_LEN_L) ? MAX_LEN_L : length;
  assign next_idx  = seg_index + ONE;
  assign start_acc = (state == IDLE) && start;
  assign hs        = (state == EMIT) && seg_ready;
  assign last_seg  = (seg_index == len_q - ONE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      snap_q    <= '0;
      len_q     <= '0;
      seg_out   <= '0;
      seg_index <= '0;
      seg_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            snap_q    <= body_in;
            len_q     <= len_c;
            seg_index <= '0;
            busy      <= 1'b1;
            if (len_c != '0) begin
              state     <= EMIT;
              seg_valid <= 1'b1;
              seg_out   <= seg_at(body_in, '0);
            end else begin
              state <= FINISH;
              done  <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (seg_ready) begin
            if (last_seg) begin
              state     <= FINISH;
              seg_valid <= 1'b0;
              seg_out   <= '0;
              seg_index <= '0;
              done      <= 1'b1;
            end else begin
              seg_index <= next_idx;
              seg_out   <= seg_at(snap_q, next_idx);
            end
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SNAKE_SELF_COLLIDE_EN
  logic hit_q;
  logic hit_n;

  // The head itself (index 0) never counts as a collision.
  assign hit_n = hit_q | ((seg_index != '0) && (seg_out == seg_at(snap_q, '0)));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hit_q   <= 1'b0;
      collide <= 1'b0;
    end else if (start_acc) begin
      hit_q   <= 1'b0;
      collide <= 1'b0;
    end else if (hs) begin
      hit_q <= hit_n;
      if (last_seg) collide <= hit_n;
    end
  end
`else
  logic unused_ok;
  assign unused_ok = start_acc ^ hs;
  assign collide   = 1'b0;
`endif

endmodule
